// File: rtl/wiener_coef_bank_ctrl.sv
// Ping-pong bank controller for the Wiener coefficient RAM: the loader fills the shadow
// bank, and a completed set becomes active only between decode frames.
module wiener_coef_bank_ctrl #(
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 16,
  parameter int FRAME_TIMEOUT = 4096
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              ld_wr_en,
  input  logic [ADDR_W-1:0] ld_wr_addr,
  input  logic [DATA_W-1:0] ld_wr_data,
  input  logic              dec_frame_start,
  input  logic              dec_frame_done,
  input  logic              dec_rd_en,
  input  logic [ADDR_W-1:0] dec_rd_addr,
  output logic [DATA_W-1:0] dec_rd_data,
  output logic              dec_rd_valid,
  output logic              ram_wr_en,
  output logic [ADDR_W:0]   ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic [ADDR_W:0]   ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              bank_sel,
  output logic              coef_valid,
  output logic [7:0]        swap_cnt,
  output logic              seq_err,
  output logic              ovf,
  output logic              frame_to
);

  localparam int TCNT_W = (FRAME_TIMEOUT > 1) ? $clog2(FRAME_TIMEOUT) : 1;

  typedef enum logic [1:0] {LD_IDLE, LD_FILL, LD_PEND} ld_state_t;
  typedef enum logic       {F_IDLE, F_ACTIVE}          f_state_t;

  ld_state_t         ld_q, ld_d;
  f_state_t          f_q, f_d;
  logic [ADDR_W:0]   fcnt_q, fcnt_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              bank_q, bank_d;
  logic              fbank_q, fbank_d;
  logic              cvalid_q, cvalid_d;
  logic [7:0]        swap_cnt_q, swap_cnt_d;
  logic              ovf_q, ovf_d;
  logic              frame_to_q, frame_to_d;
  logic              rd_valid_q;
  logic              wr_accept;
  logic              seq_err_c;
  logic              swap;

  // Swap is judged on registered state only, so the done cycle of a frame never swaps.
  assign swap = (ld_q == LD_PEND) && (f_q == F_IDLE);

  always_comb begin
    bank_d     = bank_q ^ swap;
    cvalid_d   = cvalid_q | swap;
    swap_cnt_d = swap_cnt_q + {7'd0, swap};
  end

  always_comb begin
    ld_d      = ld_q;
    fcnt_d    = fcnt_q;
    ovf_d     = ovf_q;
    wr_accept = 1'b0;
    seq_err_c = 1'b0;
    unique case (ld_q)
      LD_IDLE: begin
        if (ld_wr_en) begin
          if (ld_wr_addr == '0) begin
            wr_accept = 1'b1;
            fcnt_d    = (ADDR_W+1)'(1);
            ld_d      = LD_FILL;
          end else begin
            seq_err_c = 1'b1;
          end
        end
      end
      LD_FILL: begin
        if (ld_wr_en) begin
          if (ld_wr_addr == '0) begin
            wr_accept = 1'b1;
            seq_err_c = 1'b1;
            fcnt_d    = (ADDR_W+1)'(1);
          end else if (ld_wr_addr == fcnt_q[ADDR_W-1:0]) begin
            wr_accept = 1'b1;
            fcnt_d    = fcnt_q + (ADDR_W+1)'(1);
            if (ld_wr_addr == '1) ld_d = LD_PEND;
          end else begin
            seq_err_c = 1'b1;
            fcnt_d    = '0;
            ld_d      = LD_IDLE;
          end
        end
      end
      LD_PEND: begin
        if (ld_wr_en) ovf_d = 1'b1;
        if (swap) begin
          ld_d   = LD_IDLE;
          fcnt_d = '0;
        end
      end
      default: begin
        ld_d   = LD_IDLE;
        fcnt_d = '0;
      end
    endcase
  end

  // A frame always reads the bank that is active after its start edge.
  always_comb begin
    f_d        = f_q;
    tcnt_d     = tcnt_q;
    fbank_d    = fbank_q;
    frame_to_d = 1'b0;
    unique case (f_q)
      F_IDLE: begin
        if (dec_frame_start) begin
          f_d     = F_ACTIVE;
          tcnt_d  = '0;
          fbank_d = bank_d;
        end
      end
      F_ACTIVE: begin
        if (dec_frame_done && dec_frame_start) begin
          tcnt_d  = '0;
          fbank_d = bank_d;
        end else if (dec_frame_done) begin
          f_d = F_IDLE;
        end else if (tcnt_q == TCNT_W'(FRAME_TIMEOUT - 1)) begin
          f_d        = F_IDLE;
          frame_to_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      default: f_d = F_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      ld_q       <= LD_IDLE;
      f_q        <= F_IDLE;
      fcnt_q     <= '0;
      tcnt_q     <= '0;
      bank_q     <= 1'b0;
      fbank_q    <= 1'b0;
      cvalid_q   <= 1'b0;
      swap_cnt_q <= '0;
      ovf_q      <= 1'b0;
      frame_to_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      ld_q       <= ld_d;
      f_q        <= f_d;
      fcnt_q     <= fcnt_d;
      tcnt_q     <= tcnt_d;
      bank_q     <= bank_d;
      fbank_q    <= fbank_d;
      cvalid_q   <= cvalid_d;
      swap_cnt_q <= swap_cnt_d;
      ovf_q      <= ovf_d;
      frame_to_q <= frame_to_d;
      rd_valid_q <= dec_rd_en;
    end
  end

  // Write side is zero-latency from the loader; the active bank is never addressed.
  assign ram_wr_en    = wr_accept & ~reset;
  assign ram_wr_addr  = ram_wr_en ? {~bank_q, ld_wr_addr} : '0;
  assign ram_wr_data  = ram_wr_en ? ld_wr_data : '0;
  assign seq_err      = seq_err_c & ~reset;

  assign ram_rd_addr  = {((f_q == F_ACTIVE) ? fbank_q : bank_q), dec_rd_addr};
  assign dec_rd_valid = rd_valid_q;
  assign dec_rd_data  = ram_rd_data;

  assign bank_sel     = bank_q;
  assign coef_valid   = cvalid_q;
  assign swap_cnt     = swap_cnt_q;
  assign ovf          = ovf_q;
  assign frame_to     = frame_to_q;

endmodule

// File: tb/tb_wiener_coef_bank_ctrl.sv
// Bench for wiener_coef_bank_ctrl: directed sequence with random data and reads, checked
// every cycle against a set-level reference model and an external 512x16 RAM.
module tb_wiener_coef_bank_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ld_wr_en = 1'b0;
  logic [7:0]  ld_wr_addr = '0;
  logic [15:0] ld_wr_data = '0;
  logic        dec_frame_start = 1'b0;
  logic        dec_frame_done = 1'b0;
  logic        dec_rd_en = 1'b0;
  logic [7:0]  dec_rd_addr = '0;
  logic [15:0] dec_rd_data;
  logic        dec_rd_valid;
  logic        ram_wr_en;
  logic [8:0]  ram_wr_addr;
  logic [15:0] ram_wr_data;
  logic [8:0]  ram_rd_addr;
  logic [15:0] ram_rd_data;
  logic        bank_sel;
  logic        coef_valid;
  logic [7:0]  swap_cnt;
  logic        seq_err;
  logic        ovf;
  logic        frame_to;

  wiener_coef_bank_ctrl #(.ADDR_W(8), .DATA_W(16), .FRAME_TIMEOUT(TO)) dut (
    .clk_in(clk), .reset(reset),
    .ld_wr_en(ld_wr_en), .ld_wr_addr(ld_wr_addr), .ld_wr_data(ld_wr_data),
    .dec_frame_start(dec_frame_start), .dec_frame_done(dec_frame_done),
    .dec_rd_en(dec_rd_en), .dec_rd_addr(dec_rd_addr),
    .dec_rd_data(dec_rd_data), .dec_rd_valid(dec_rd_valid),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .bank_sel(bank_sel), .coef_valid(coef_valid), .swap_cnt(swap_cnt),
    .seq_err(seq_err), .ovf(ovf), .frame_to(frame_to)
  );

  always #5 clk = ~clk;

  // External coefficient RAM, one-cycle registered read.
  logic        tb_clear = 1'b1;
  logic [15:0] ram_mem [0:511];
  always @(posedge clk) begin
    if (tb_clear) begin
      for (int i = 0; i < 512; i++) ram_mem[i] <= '0;
      ram_rd_data <= '0;
    end else begin
      if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_wr_data;
      ram_rd_data <= ram_mem[ram_rd_addr];
    end
  end

  int n_chk = 0;
  int n_err = 0;

  // Reference model: expected next index of the set being loaded (0 = waiting for a start).
  logic [15:0] m_mem [0:511];
  int   m_next, m_swaps, m_age;
  bit   m_pend, m_bank, m_cvalid, m_ovf, m_active, m_fbank, m_to, m_rvalid;
  logic [15:0] m_rdata;

  int   cyc_no = 0;
  int   wr_seen = 0;
  int   to_cyc = -1;
  bit   last_serr = 1'b0;
  bit   ka_mode = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_next = 0; m_swaps = 0; m_age = 0;
    m_pend = 0; m_bank = 0; m_cvalid = 0; m_ovf = 0;
    m_active = 0; m_fbank = 0; m_to = 0; m_rvalid = 0; m_rdata = '0;
  endtask

  // One clock cycle: drive inputs, check all outputs at the falling edge, advance the model.
  task automatic cyc(input bit we, input logic [7:0] wa, input logic [15:0] wd,
                     input bit fs, input bit fd, input bit re, input logic [7:0] ra);
    bit acc, serr, swp, rb;
    logic [8:0] ridx;
    ld_wr_en = we; ld_wr_addr = wa; ld_wr_data = wd;
    dec_frame_start = fs; dec_frame_done = fd;
    dec_rd_en = re; dec_rd_addr = ra;
    acc = 0; serr = 0;
    if (we && !m_pend) begin
      if (wa == 8'd0) begin
        acc = 1; serr = (m_next != 0);
      end else if (m_next != 0 && int'(wa) == m_next) begin
        acc = 1;
      end else begin
        serr = 1;
      end
    end
    rb = m_active ? m_fbank : m_bank;
    ridx = {rb, ra};
    @(negedge clk);
    cyc_no++;
    if (ram_wr_en === 1'b1) wr_seen++;
    if (frame_to === 1'b1) to_cyc = cyc_no;
    last_serr = seq_err;
    chk("ram_wr_en", ram_wr_en, acc);
    if (acc) begin
      chk("ram_wr_addr", ram_wr_addr, {~m_bank, wa});
      chk("ram_wr_data", ram_wr_data, wd);
    end
    chk("seq_err", seq_err, serr);
    chk("ram_rd_addr", ram_rd_addr, ridx);
    chk("bank_sel", bank_sel, m_bank);
    chk("coef_valid", coef_valid, m_cvalid);
    chk("swap_cnt", swap_cnt, 32'(m_swaps));
    chk("ovf", ovf, m_ovf);
    chk("frame_to", frame_to, m_to);
    chk("dec_rd_valid", dec_rd_valid, m_rvalid);
    if (m_rvalid) chk("dec_rd_data", dec_rd_data, m_rdata);
    // advance the model across the coming edge
    m_rvalid = re;
    m_rdata  = m_mem[ridx];
    swp = m_pend && !m_active;
    if (we && m_pend) m_ovf = 1;
    if (acc) begin
      m_mem[{~m_bank, wa}] = wd;
      if (wa == 8'd255) begin m_pend = 1; m_next = 0; end
      else m_next = int'(wa) + 1;
    end else if (serr) begin
      m_next = 0;
    end
    if (swp) begin
      m_bank = ~m_bank; m_cvalid = 1; m_swaps = (m_swaps + 1) % 256; m_pend = 0;
    end
    m_to = 0;
    if (!m_active) begin
      if (fs) begin m_active = 1; m_age = 0; m_fbank = m_bank; end
    end else if (fs && fd) begin
      m_age = 0; m_fbank = m_bank;
    end else if (fd) begin
      m_active = 0;
    end else if (m_age == TO - 1) begin
      m_active = 0; m_to = 1;
    end else begin
      m_age++;
    end
    @(posedge clk);
    #1;
  endtask

  // Cycle with a random read; in keep-alive mode an active frame is restarted every 8 cycles.
  task automatic tick(input bit we, input logic [7:0] wa, input logic [15:0] wd);
    bit ka;
    ka = ka_mode && (cyc_no % 8 == 0);
    cyc(we, wa, wd, ka, ka, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
  endtask

  task automatic fill_set(input int lo, input int hi, input bit rnd, input logic [15:0] base);
    for (int a = lo; a <= hi; a++) begin
      if ($urandom_range(0, 3) == 0) tick(1'b0, 8'd0, 16'd0);
      tick(1'b1, 8'(a), rnd ? 16'($urandom) : base + 16'(a));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ld_wr_en = 1'b1; ld_wr_addr = 8'd0; ld_wr_data = 16'hABCD;
    dec_frame_start = 1'b0; dec_frame_done = 1'b0; dec_rd_en = 1'b0;
    @(negedge clk);
    chk("rst_ram_wr_en", ram_wr_en, 1'b0);
    chk("rst_seq_err", seq_err, 1'b0);
    @(posedge clk); #1;
    ld_wr_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk("rst_bank_sel", bank_sel, 1'b0);
    chk("rst_coef_valid", coef_valid, 1'b0);
    chk("rst_swap_cnt", swap_cnt, 8'd0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_frame_to", frame_to, 1'b0);
    chk("rst_dec_rd_valid", dec_rd_valid, 1'b0);
  endtask

  initial begin
    int wr0, start_cyc;
    for (int i = 0; i < 512; i++) m_mem[i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tb_clear = 1'b0;
    do_reset();

    // Set 1 with the decoder idle: shadow bank 1 filled, swap one cycle after addr 255.
    wr0 = wr_seen;
    fill_set(0, 255, 1'b0, 16'h1000);
    chk("set1_wr_count", 32'(wr_seen - wr0), 32'd256);
    chk("set1_bank_before_swap", bank_sel, 1'b0);
    tick(1'b0, 8'd0, 16'd0);
    chk("set1_bank_after_swap", bank_sel, 1'b1);
    chk("set1_coef_valid", coef_valid, 1'b1);
    chk("set1_swap_cnt", swap_cnt, 8'd1);
    cyc(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, 8'd5);
    chk("set1_rd_addr5", dec_rd_data, 16'h1005);

    // Set 2 loaded during a long frame: no swap until the cycle after done.
    cyc(1'b0, 8'd0, 16'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    ka_mode = 1'b1;
    fill_set(0, 255, 1'b0, 16'h2000);
    tick(1'b0, 8'd0, 16'd0);
    tick(1'b0, 8'd0, 16'd0);
    chk("set2_no_swap_in_frame", bank_sel, 1'b1);
    cyc(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1, 8'd9);
    chk("set2_rd_old_bank", dec_rd_data, 16'h1009);
    for (int k = 0; k < 3; k++) tick(1'b1, 8'($urandom_range(0, 255)), 16'($urandom));
    chk("set2_ovf", ovf, 1'b1);
    ka_mode = 1'b0;
    cyc(1'b0, 8'd0, 16'd0, 1'b0, 1'b1, 1'b0, 8'd0);
    chk("set2_no_swap_on_done", bank_sel, 1'b1);
    tick(1'b0, 8'd0, 16'd0);
    chk("set2_bank_after_swap", bank_sel, 1'b0);
    chk("set2_swap_cnt", swap_cnt, 8'd2);

    // Sequence errors: 0,1,2,7 aborts; 0,1,0 restarts.
    tick(1'b1, 8'd0, 16'($urandom));
    tick(1'b1, 8'd1, 16'($urandom));
    tick(1'b1, 8'd2, 16'($urandom));
    tick(1'b1, 8'd7, 16'($urandom));
    chk("seq_err_addr7", last_serr, 1'b1);
    tick(1'b1, 8'd0, 16'($urandom));
    tick(1'b1, 8'd1, 16'($urandom));
    tick(1'b1, 8'd0, 16'($urandom));
    chk("seq_err_restart", last_serr, 1'b1);
    fill_set(1, 255, 1'b1, 16'd0);
    tick(1'b0, 8'd0, 16'd0);
    tick(1'b0, 8'd0, 16'd0);
    chk("set3_swap_cnt", swap_cnt, 8'd3);
    chk("set3_bank", bank_sel, 1'b1);

    // Frame without done times out; the pending set swaps right after.
    fill_set(0, 254, 1'b1, 16'd0);
    cyc(1'b0, 8'd0, 16'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    start_cyc = cyc_no;
    tick(1'b1, 8'd255, 16'($urandom));
    to_cyc = -1;
    for (int k = 0; k < 40 && to_cyc < 0; k++) tick(1'b0, 8'd0, 16'd0);
    chk("to_seen", 32'(to_cyc >= 0), 32'd1);
    // frame_to registers 16 edges after the start edge, seen in the 17th following cycle
    chk("to_delay", 32'(to_cyc - start_cyc), 32'd17);
    chk("to_swap_bank", bank_sel, 1'b0);
    chk("to_swap_cnt", swap_cnt, 8'd4);

    // Reset mid-fill and mid-frame, then a clean fill.
    fill_set(0, 89, 1'b1, 16'd0);
    cyc(1'b0, 8'd0, 16'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    fill_set(90, 99, 1'b1, 16'd0);
    do_reset();
    tick(1'b1, 8'd1, 16'($urandom));
    chk("post_rst_idle_seq_err", last_serr, 1'b1);
    fill_set(0, 255, 1'b1, 16'd0);
    tick(1'b0, 8'd0, 16'd0);
    tick(1'b0, 8'd0, 16'd0);
    chk("post_rst_bank", bank_sel, 1'b1);
    chk("post_rst_coef_valid", coef_valid, 1'b1);
    chk("post_rst_swap_cnt", swap_cnt, 8'd1);
    for (int k = 0; k < 4; k++) tick(1'b0, 8'd0, 16'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/wiener_coef_bank_ctrl.md
Name: wiener_coef_bank_ctrl

Overview:
- Ping-pong controller for the Wiener coefficient RAM (512x16, one write port, one read port). Bank = address MSB.
- Sits between the host parameter receiver (256-word write stream) and the Wiener decode engine (coefficient reads per decode frame).
- The receiver always fills the shadow bank. A completed set swaps in only between decode frames, so a frame never mixes old and new coefficients.

Parameters:
- ADDR_W, 8, coefficient index width; set size = 2**ADDR_W = 256 words.
- DATA_W, 16, coefficient width.
- FRAME_TIMEOUT, 4096, max cycles a decode frame may stay active before forced termination.

Ports:
- clk_in  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- ld_wr_en  in  1  loader write strobe, one word per asserted cycle.
- ld_wr_addr  in  ADDR_W  loader word index.
- ld_wr_data  in  DATA_W  loader word.
- dec_frame_start  in  1  decode-frame start pulse.
- dec_frame_done  in  1  decode-frame end pulse.
- dec_rd_en  in  1  coefficient read request.
- dec_rd_addr  in  ADDR_W  coefficient index.
- dec_rd_data  out  DATA_W  read data.
- dec_rd_valid  out  1  read data valid.
- ram_wr_en  out  1  RAM write enable.
- ram_wr_addr  out  ADDR_W+1  RAM write address.
- ram_wr_data  out  DATA_W  RAM write data.
- ram_rd_addr  out  ADDR_W+1  RAM read address (RAM read latency 1 cycle).
- ram_rd_data  in  DATA_W  RAM read data.
- bank_sel  out  1  current active bank.
- coef_valid  out  1  at least one complete set has been swapped in.
- swap_cnt  out  8  number of completed swaps, wraps 255->0.
- seq_err  out  1  one-cycle pulse on a loader sequence error.
- ovf  out  1  sticky: loader word dropped while a swap was pending.
- frame_to  out  1  one-cycle pulse on frame timeout.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs are 0; bank_sel=0.
  - Loader FSM = LD_IDLE; frame FSM = F_IDLE; fill counter = 0.
  - Reset mid-fill or mid-frame discards all progress. RAM contents are untouched but treated as invalid (coef_valid=0).
- Loader FSM (LD_IDLE, LD_FILL, LD_PEND), fill counter fcnt, width ADDR_W+1:
  - LD_IDLE: ld_wr_en with addr 0 writes the word, sets fcnt=1, goes to LD_FILL. ld_wr_en with addr≠0 drops the word and pulses seq_err.
  - LD_FILL, ld_wr_en with addr==fcnt: writes the word, fcnt+1. When the word at addr 255 is written, go to LD_PEND.
  - LD_FILL, ld_wr_en with addr==0: restart. The word is written, fcnt=1, seq_err pulses.
  - LD_FILL, any other address: word dropped, seq_err pulses, go to LD_IDLE.
  - LD_PEND: every ld_wr_en is dropped and sets ovf (sticky until reset). Leave LD_PEND for LD_IDLE on the swap cycle.
  - Accepted write: ram_wr_en=1, ram_wr_addr={~bank_sel, ld_wr_addr}, ram_wr_data=ld_wr_data, combinational from inputs (same cycle, zero latency). The active bank is never written.
- Frame FSM (F_IDLE, F_ACTIVE), timeout counter tcnt:
  - F_IDLE: dec_frame_start -> F_ACTIVE; tcnt=0; frame_bank latched = bank_sel value after this edge.
  - F_ACTIVE: dec_frame_done -> F_IDLE.
  - F_ACTIVE, simultaneous dec_frame_done and dec_frame_start: stay F_ACTIVE; re-latch frame_bank; tcnt=0.
  - F_ACTIVE: dec_frame_start without done is ignored.
  - F_ACTIVE: tcnt reaching FRAME_TIMEOUT-1 -> F_IDLE and frame_to pulses.
- Swap:
  - Condition: LD_PEND and frame FSM is F_IDLE at the start of the cycle.
  - On swap: bank_sel toggles, coef_valid=1, swap_cnt+1, loader -> LD_IDLE.
  - If dec_frame_start arrives in the swap cycle, that frame uses the new bank.
  - No swap while F_ACTIVE, including the cycle dec_frame_done is sampled. The earliest swap is the following cycle.
- Read path:
  - ram_rd_addr={F_ACTIVE ? frame_bank : bank_sel, dec_rd_addr}, combinational.
  - dec_rd_valid = dec_rd_en delayed 1 cycle; dec_rd_data = ram_rd_data passed through.
  - Reads are accepted every cycle. Reads while coef_valid=0 return RAM data but dec_rd_valid still asserts; the consumer gates on coef_valid.
- Write and read streams are independent and may be simultaneous every cycle. They never address the same bank during a frame.

Test Plan:
- Reset, write words 0..255 (data=addr+16'h1000) with decoder idle -> exactly 256 ram_wr_en with ram_wr_addr 256..511; the swap fires the cycle after the addr-255 write; bank_sel=1, coef_valid=1, swap_cnt=1; reading addr 5 gives dec_rd_data=16'h1005 one cycle later.
- Start a frame, then complete a second set (data=addr+16'h2000) -> no swap while active; reads during the frame return 16'h10xx; swap happens the cycle after dec_frame_done; swap_cnt=2, bank_sel=0.
- In LD_PEND with a frame active, write 3 extra words -> ovf=1, no ram_wr_en, no seq_err.
- Fill sequence 0,1,2,7 -> seq_err pulse on the addr-7 cycle, loader returns to LD_IDLE; then sequence 0,1,0 -> seq_err pulse, restart with fcnt=1, addr-0 word written twice.
- Start a frame and never send done, FRAME_TIMEOUT=16 -> frame_to pulses 16 cycles after start; a pending swap completes the next cycle.
- Assert reset at fcnt=100 -> loader returns to LD_IDLE, fcnt=0, bank_sel=0, coef_valid=0, ovf=0, swap_cnt=0; a new full fill then succeeds.
